// File: rtl/conv_mac_pkg.sv
// Shared types and sizing helpers for the tiled conv2d MAC array.
package conv_mac_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int COEF_W_DEF = 8;
    localparam int SUM_W_DEF  = 32;

    typedef logic signed [DATA_W_DEF-1:0] data_t;
    typedef logic signed [COEF_W_DEF-1:0] coef_t;
    typedef logic signed [SUM_W_DEF-1:0]  sum_t;

    // Slice counter width; one spare bit keeps NUM_SLICES==1 legal.
    function automatic int slice_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/conv_mac_dot.sv
// One CIN_PAR*K*K signed dot product reduced by a combinational adder tree.
module conv_mac_dot
    import conv_mac_pkg::*;
#(
    parameter int N      = 72,
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
) (
    input  logic [N*DATA_W-1:0]     win,
    input  logic [N*COEF_W-1:0]     coef,
    output logic signed [SUM_W-1:0] sum
);

    localparam int PW = DATA_W + COEF_W;
    localparam int M  = 1 << $clog2(N);

    logic signed [PW-1:0]    prod [N];
    logic signed [SUM_W-1:0] node [2*M];

    for (genvar n = 0; n < N; n++) begin : g_prod
        logic signed [PW-1:0] a;
        logic signed [PW-1:0] b;
        assign a       = PW'($signed(win[n*DATA_W +: DATA_W]));
        assign b       = PW'($signed(coef[n*COEF_W +: COEF_W]));
        assign prod[n] = a * b;
    end

    // Heap-ordered tree: leaves at M.., node i sums children 2i and 2i+1.
    always_comb begin
        node = '{default: '0};
        for (int n = 0; n < N; n++) begin
            node[M+n] = SUM_W'(prod[n]);
        end
        for (int i = M - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
    end

    assign sum = node[1];

endmodule

// File: rtl/conv2d_mac_tiled.sv
// Tiled conv2d MAC: accumulates NUM_SLICES channel beats per result tile.
// Define CONV_MAC_RELU_EN to clamp negative final tile values to zero.
module conv2d_mac_tiled
    import conv_mac_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int COEF_W      = COEF_W_DEF,
    parameter int WIN_SIZE    = 3,
    parameter int PIX_PER_CLK = 8,
    parameter int CIN_PAR     = 8,
    parameter int NUM_SLICES  = 4,
    parameter int COUT        = 16,
    parameter int SUM_W       = SUM_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic [PIX_PER_CLK*CIN_PAR*WIN_SIZE*WIN_SIZE*DATA_W-1:0] in_window,
    input  logic [COUT*CIN_PAR*WIN_SIZE*WIN_SIZE*COEF_W-1:0]        in_kernel,
    input  logic abort,
    output logic out_valid,
    input  logic out_ready,
    output logic [PIX_PER_CLK*COUT*SUM_W-1:0] out_result,
    output logic [$clog2(NUM_SLICES):0]       slice_idx,
    output logic busy
);

    localparam int K   = WIN_SIZE;
    localparam int N   = CIN_PAR * K * K;
    localparam int SCW = slice_cnt_w(NUM_SLICES);

    typedef logic [SCW-1:0] slice_cnt_t;
    typedef logic signed [SUM_W-1:0] acc_t;

    localparam slice_cnt_t LAST = slice_cnt_t'(NUM_SLICES - 1);

    acc_t beat_sum [PIX_PER_CLK][COUT];
    acc_t acc      [PIX_PER_CLK][COUT];
    acc_t tot      [PIX_PER_CLK][COUT];
    acc_t fin      [PIX_PER_CLK][COUT];
    acc_t res_q    [PIX_PER_CLK][COUT];

    logic is_last;
    logic first;
    logic accept;

    for (genvar l = 0; l < PIX_PER_CLK; l++) begin : g_pix
        for (genvar o = 0; o < COUT; o++) begin : g_cout
            conv_mac_dot #(
                .N      (N),
                .DATA_W (DATA_W),
                .COEF_W (COEF_W),
                .SUM_W  (SUM_W)
            ) u_dot (
                .win  (in_window[l*N*DATA_W +: N*DATA_W]),
                .coef (in_kernel[o*N*COEF_W +: N*COEF_W]),
                .sum  (beat_sum[l][o])
            );
            assign out_result[(l*COUT+o)*SUM_W +: SUM_W] = res_q[l][o];
        end
    end

    assign is_last  = slice_idx == LAST;
    assign first    = slice_idx == '0;
    assign busy     = !first;
    assign in_ready = !(is_last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready && !abort;

    // Slice 0 starts from zero, so a discarded partial never leaks forward.
    always_comb begin
        for (int l = 0; l < PIX_PER_CLK; l++) begin
            for (int o = 0; o < COUT; o++) begin
                tot[l][o] = (first ? '0 : acc[l][o]) + beat_sum[l][o];
`ifdef CONV_MAC_RELU_EN
                fin[l][o] = tot[l][o][SUM_W-1] ? '0 : tot[l][o];
`else
                fin[l][o] = tot[l][o];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slice_idx <= '0;
            out_valid <= 1'b0;
            acc       <= '{default: '0};
            res_q     <= '{default: '0};
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (abort) begin
                slice_idx <= '0;
            end else if (accept) begin
                if (is_last) begin
                    res_q     <= fin;
                    out_valid <= 1'b1;
                    slice_idx <= '0;
                end else begin
                    acc       <= tot;
                    slice_idx <= slice_idx + slice_cnt_t'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv2d_mac_tiled.sv
// Bench for conv2d_mac_tiled: spec-level model, per-cycle compare, directed tiles.
module tb_conv2d_mac_tiled;

    localparam int P  = 8;
    localparam int C  = 8;
    localparam int K  = 3;
    localparam int CO = 16;
    localparam int NS = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int SW = 32;
    localparam int WB = P*C*K*K*DW;
    localparam int KB = CO*C*K*K*CW;
    localparam int RB = P*CO*SW;

`ifdef CONV_MAC_RELU_EN
    localparam longint E_NEG  = 0;
    localparam longint E_NEG1 = 0;
`else
    localparam longint E_NEG  = -4681728;
    localparam longint E_NEG1 = -432;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_valid1 = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b1;
    logic [WB-1:0] in_window = '0;
    logic [KB-1:0] in_kernel = '0;

    logic          in_ready, out_valid, busy;
    logic [2:0]    slice_idx;
    logic [RB-1:0] out_result;
    logic          in_ready1, out_valid1, busy1;
    logic [0:0]    slice_idx1;
    logic [RB-1:0] out_result1;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int     wv [P][C][K][K];
    int     kv [CO][C][K][K];
    longint bs [P][CO];

    longint               m_part [P][CO];
    logic signed [SW-1:0] m_res  [P][CO];
    logic signed [SW-1:0] m1_res [P][CO];
    int m_idx;
    bit m_ov, m1_ov, m_rdy;

    conv2d_mac_tiled dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_window(in_window), .in_kernel(in_kernel),
        .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result),
        .slice_idx(slice_idx), .busy(busy)
    );

    conv2d_mac_tiled #(.NUM_SLICES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_window(in_window), .in_kernel(in_kernel),
        .abort(1'b0),
        .out_valid(out_valid1), .out_ready(1'b1),
        .out_result(out_result1),
        .slice_idx(slice_idx1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Plain-arithmetic beat sum from the driven integer tables.
    always_comb begin
        for (int l = 0; l < P; l++) begin
            for (int o = 0; o < CO; o++) begin
                longint s;
                s = 0;
                for (int c = 0; c < C; c++)
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            s += longint'(wv[l][c][i][j]) * longint'(kv[o][c][i][j]);
                bs[l][o] = s;
            end
        end
    end

    function automatic logic signed [SW-1:0] fin(input longint v);
        logic signed [SW-1:0] t;
        t = v[SW-1:0];
`ifdef CONV_MAC_RELU_EN
        if (t < 0) t = '0;
`endif
        return t;
    endfunction

    assign m_rdy = !(m_idx == NS-1 && m_ov && !out_ready);

    always @(posedge clk) begin
        if (rst) begin
            m_idx <= 0;
            m_ov  <= 1'b0;
            for (int l = 0; l < P; l++)
                for (int o = 0; o < CO; o++)
                    m_res[l][o] <= '0;
        end else begin
            if (m_ov && out_ready) m_ov <= 1'b0;
            if (abort) begin
                m_idx <= 0;
            end else if (in_valid && m_rdy) begin
                for (int l = 0; l < P; l++)
                    for (int o = 0; o < CO; o++) begin
                        longint base;
                        base = (m_idx == 0) ? 0 : m_part[l][o];
                        if (m_idx == NS-1) m_res[l][o] <= fin(base + bs[l][o]);
                        else m_part[l][o] <= base + bs[l][o];
                    end
                if (m_idx == NS-1) begin
                    m_ov  <= 1'b1;
                    m_idx <= 0;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m1_ov <= 1'b0;
            for (int l = 0; l < P; l++)
                for (int o = 0; o < CO; o++)
                    m1_res[l][o] <= '0;
        end else if (in_valid1) begin
            m1_ov <= 1'b1;
            for (int l = 0; l < P; l++)
                for (int o = 0; o < CO; o++)
                    m1_res[l][o] <= fin(bs[l][o]);
        end else begin
            m1_ov <= 1'b0;
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_tile(input string nm, input logic [RB-1:0] act,
                            input logic signed [SW-1:0] exp [P][CO]);
        int bl, bo;
        bl = -1;
        bo = -1;
        for (int l = 0; l < P; l++)
            for (int o = 0; o < CO; o++)
                if (bl < 0 && act[(l*CO+o)*SW +: SW] !== exp[l][o]) begin
                    bl = l;
                    bo = o;
                end
        n_vec++;
        if (bl >= 0) begin
            n_err++;
            $display("FAIL %s[%0d][%0d]: got %0d expected %0d", nm, bl, bo,
                     $signed(act[(bl*CO+bo)*SW +: SW]), exp[bl][bo]);
        end
    endtask

    function automatic longint res_at(input logic [RB-1:0] r, input int l, input int o);
        logic signed [SW-1:0] v;
        v = r[(l*CO+o)*SW +: SW];
        return longint'(v);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_ov);
            check("in_ready", in_ready, m_rdy);
            check("slice_idx", slice_idx, m_idx);
            check("busy", busy, m_idx != 0);
            cmp_tile("out_result", out_result, m_res);
            check("ns1_in_ready", in_ready1, 1);
            check("ns1_out_valid", out_valid1, m1_ov);
            check("ns1_slice_idx", slice_idx1, 0);
            check("ns1_busy", busy1, 0);
            cmp_tile("ns1_out_result", out_result1, m1_res);
        end
    end

    // mode 0: constant window a / kernel b; mode 1: varied pattern seeded by a.
    task automatic set_beat(input int mode, input int a, input int b);
        for (int l = 0; l < P; l++)
            for (int c = 0; c < C; c++)
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++) begin
                        wv[l][c][i][j] = (mode == 0) ? a
                            : ((l*3 + c*5 + i*7 + j + a) % 17) - 8;
                        in_window[(((l*C+c)*K+i)*K+j)*DW +: DW] = DW'(wv[l][c][i][j]);
                    end
        for (int o = 0; o < CO; o++)
            for (int c = 0; c < C; c++)
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++) begin
                        kv[o][c][i][j] = (mode == 0) ? b
                            : ((o*5 + c*3 + i + j*11 + b) % 19) - 9;
                        in_kernel[(((o*C+c)*K+i)*K+j)*CW +: CW] = CW'(kv[o][c][i][j]);
                    end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        set_beat(0, 0, 0);
        step(2);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_slice_idx", slice_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_result", res_at(out_result, 0, 0), 0);

        // all-ones tile
        set_beat(0, 1, 1);
        in_valid = 1'b1;
        step(3);
        check("ones_idx3", slice_idx, 3);
        check("ones_no_early_valid", out_valid, 0);
        step(1);
        in_valid = 1'b0;
        check("ones_valid", out_valid, 1);
        check("ones_px0", res_at(out_result, 0, 0), 288);
        check("ones_px7_co15", res_at(out_result, 7, 15), 288);
        check("model_ones", m_res[4][6], 288);
        step(1);
        check("ones_drained", out_valid, 0);

        // extreme-value tile, then hold it under backpressure
        set_beat(0, -128, 127);
        in_valid = 1'b1;
        step(4);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("neg_tile", res_at(out_result, 3, 5), E_NEG);
        check("model_neg", m_res[3][5], E_NEG);

        for (int b = 0; b < 3; b++) begin
            set_beat(1, b, b);
            in_valid = 1'b1;
            step(1);
        end
        check("bp_idx3", slice_idx, 3);
        check("bp_in_ready", in_ready, 0);
        set_beat(1, 3, 3);
        step(2);
        check("bp_hold_idx", slice_idx, 3);
        check("bp_hold_tile", res_at(out_result, 3, 5), E_NEG);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step(1);
        in_valid = 1'b0;
        check("bp_tile2_valid", out_valid, 1);
        check("bp_tile2_new", res_at(out_result, 3, 5) != E_NEG, 1);
        step(1);
        check("bp_tile2_drained", out_valid, 0);

        // abort discards partial sums
        set_beat(0, 5, 5);
        in_valid = 1'b1;
        step(2);
        in_valid = 1'b0;
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_idx", slice_idx, 0);
        set_beat(0, 1, 1);
        in_valid = 1'b1;
        step(4);
        in_valid = 1'b0;
        check("abort_clean_tile", res_at(out_result, 2, 9), 288);
        step(1);
        set_beat(0, 2, 3);
        in_valid = 1'b1;
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        in_valid = 1'b0;
        check("abort_drops_beat", slice_idx, 0);

        // single-slice instance, back-to-back beats
        set_beat(0, 2, -3);
        in_valid1 = 1'b1;
        step(1);
        check("ns1_first", res_at(out_result1, 1, 1), E_NEG1);
        for (int b = 0; b < 3; b++) begin
            set_beat(1, 10 + b, 20 + b);
            step(1);
            check("ns1_continuous", out_valid1, 1);
        end
        in_valid1 = 1'b0;
        step(1);
        check("ns1_drained", out_valid1, 0);

        // reset mid-tile with a pending result
        out_ready = 1'b0;
        set_beat(0, 1, 1);
        in_valid = 1'b1;
        step(6);
        in_valid = 1'b0;
        check("pre_rst_idx", slice_idx, 2);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("post_rst_valid", out_valid, 0);
        check("post_rst_idx", slice_idx, 0);
        check("post_rst_result", res_at(out_result, 0, 0), 0);
        out_ready = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv2d_mac_tiled.md
Name: conv2d_mac_tiled

Overview:
Conv2D MAC array that processes a deep input-channel stack as NUM_SLICES beats of CIN_PAR channels each. Per beat it takes one PIX_PER_CLK window slice plus the matching kernel slice and accumulates partial sums per pixel and output channel. After the last slice it emits a registered result tile over a valid/ready handshake with backpressure. It sits between the tile/window engine and the requantiser/writeback stage.

Parameters:
DATA_W, 8, signed activation width
COEF_W, 8, signed weight width
WIN_SIZE, 3, kernel height/width K
PIX_PER_CLK, 8, output pixels processed in parallel
CIN_PAR, 8, input channels per beat
NUM_SLICES, 4, beats per output tile (total CIN = CIN_PAR*NUM_SLICES); must be >=1
COUT, 16, output channels
SUM_W, 32, accumulator/result width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  slice beat valid
in_ready  out  1  slice beat accepted when in_valid && in_ready
in_window  in  [PIX_PER_CLK][CIN_PAR][K][K] x DATA_W signed  window slice
in_kernel  in  [COUT][CIN_PAR][K][K] x COEF_W signed  kernel slice for current beat
abort  in  1  synchronous tile abort
out_valid  out  1  result tile valid
out_ready  in  1  downstream accepts result
out_result  out  [PIX_PER_CLK][COUT] x SUM_W signed  finished tile
slice_idx  out  $clog2(NUM_SLICES)+1  index of next expected slice
busy  out  1  high while slice_idx != 0

Behaviour:
- Reset: acc all 0, slice_idx=0, out_valid=0, out_result all 0, busy=0.
- Beat sum: for each (l,o), sum over c, i, j of window[l][c][i][j]*kernel[o][c][i][j]. Products are full DATA_W+COEF_W signed. The sum is sign-extended to SUM_W. All adds wrap two's-complement at SUM_W.
- Accepted beat, slice_idx < NUM_SLICES-1: acc <= (slice_idx==0 ? 0 : acc) + beat_sum; slice_idx++.
- Accepted beat, slice_idx == NUM_SLICES-1 (last): out_result <= acc + beat_sum (acc replaced by 0 for NUM_SLICES==1); out_valid<=1; slice_idx<=0. Latency: result visible one cycle after the last beat handshake.
- out_valid clears on out_valid && out_ready, unless a new last beat is accepted the same cycle, in which case it stays 1 with the new tile.
- in_ready = !(slice_idx==NUM_SLICES-1 && out_valid && !out_ready). Non-last beats are never stalled, so the next tile accumulates while the previous result waits.
- out_result holds stable while out_valid && !out_ready.
- abort (when rst=0): slice_idx<=0 and the partial accumulation is discarded. abort has priority over a same-cycle beat, which is dropped; in_ready is still reported per the rule above. A pending out_valid/out_result is unaffected.
- Reset mid-tile: everything returns to reset values and the partial tile is lost.
- in_valid with in_ready=0: no state change.

Optional Feature:
- CONV_MAC_RELU_EN defined: the final tile value is clamped to 0 when negative before loading out_result. Partial accumulations are never clamped.
- Undefined: out_result is the raw wrapped sum.

Decomposition:
- Package conv_mac_pkg: SUM_W default, sum_t/data_t/coef_t typedefs, and a clog2-based slice_cnt_t helper.
- Sub-module conv_mac_dot (one CIN_PAR*K*K dot product, combinational adder tree), instantiated PIX_PER_CLK*COUT times.
- Top level holds the slice counter, accumulators, output register and handshake.

Test Plan:
- Defaults, all window=1, kernel=1, 4 beats with out_ready=1 -> out_valid exactly 1 cycle after 4th handshake; every result = 4*8*9 = 288.
- window=-128, kernel=127, 4 beats -> result = -128*127*288 = -4681728 (no ReLU); with CONV_MAC_RELU_EN -> 0.
- out_ready=0 after tile 1; stream tile 2 -> beats 0-2 accepted, in_ready=0 at slice_idx=3; tile 1 held stable; raising out_ready accepts beat 3 the same cycle; tile 2 appears next cycle.
- abort after 2 beats of values 5, then a full tile of 1s -> result 288 (no carry-over); abort together with a beat -> beat ignored, slice_idx=0.
- NUM_SLICES=1, back-to-back beats with out_ready=1 -> one result per cycle, in_ready stays 1, out_valid continuously 1.
- rst asserted at slice_idx=2 with out_valid=1 -> next cycle out_valid=0, slice_idx=0, out_result=0.
